// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SLICE-bit segment is resolved per stage,
// with the inter-segment carry registered and operand/result skew handled inside the pipe.
module cla_pipe_addsub #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int L  = WIDTH / SLICE;
   localparam int NG = SLICE / 4;

   if (((WIDTH % SLICE) != 0) || ((SLICE % 4) != 0)) begin : g_param_check
      $error("cla_pipe_addsub: WIDTH must be a multiple of SLICE and SLICE a multiple of 4");
   end

   // Handshake: valid/ready. A transfer happens on a rising edge where valid and ready
   // are both high. The whole pipe advances only when the output slot is empty or
   // being drained (w_en); otherwise every register, valid bits included, holds.

   // Two-level CLA over one slice. Returns {carry out, carry into MSB, sum}.
   function automatic logic [SLICE+1:0] cla_slice(input logic [SLICE-1:0] x,
                                                  input logic [SLICE-1:0] y,
                                                  input logic             ci);
      logic [SLICE-1:0] g;
      logic [SLICE-1:0] p;
      logic [NG-1:0]    gg;
      logic [NG-1:0]    gp;
      logic [NG:0]      gc;
      logic [SLICE:0]   c;
      logic             t;
      g = x & y;
      p = x ^ y;
      for (int j = 0; j < NG; j++) begin
         gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
                 (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end
      // Group carries as flat sum-of-products over G/P, so no ripple between groups.
      gc[0] = ci;
      for (int j = 1; j <= NG; j++) begin
         gc[j] = 1'b0;
         t     = 1'b1;
         for (int m = j - 1; m >= 0; m--) begin
            gc[j] = gc[j] | (t & gg[m]);
            t     = t & gp[m];
         end
         gc[j] = gc[j] | (t & ci);
      end
      for (int j = 0; j < NG; j++) begin
         c[4*j] = gc[j];
         for (int k = 1; k < 4; k++) begin
            c[4*j+k] = 1'b0;
            t        = 1'b1;
            for (int m = k - 1; m >= 0; m--) begin
               c[4*j+k] = c[4*j+k] | (t & g[4*j+m]);
               t        = t & p[4*j+m];
            end
            c[4*j+k] = c[4*j+k] | (t & gc[j]);
         end
      end
      c[SLICE] = gc[NG];
      return {c[SLICE], c[SLICE-1], p ^ c[SLICE-1:0]};
   endfunction

   logic             w_en;
   logic             w_push;
   logic [L-1:0]     r_vld;
   logic [WIDTH-1:0] r_a    [L];
   logic [WIDTH-1:0] r_b    [L];
   logic [WIDTH-1:0] r_s    [L];
   logic             r_c    [L];
   logic [SLICE+1:0] w_res  [L];
   logic [WIDTH-1:0] w_psum [L];

   logic             r_out_vld;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   assign w_en     = ~r_out_vld | out_ready;
   assign in_ready = w_en & ~rst;
   assign w_push   = in_valid & in_ready;

   // Stage k resolves slice k and merges it into the partial sum carried down the pipe.
   always_comb begin
      for (int k = 0; k < L; k++) begin
         w_res[k]  = cla_slice(r_a[k][k*SLICE +: SLICE], r_b[k][k*SLICE +: SLICE], r_c[k]);
         w_psum[k] = r_s[k];
         w_psum[k][k*SLICE +: SLICE] = w_res[k][SLICE-1:0];
      end
   end

   // Data registers are not reset; only valid bits and the visible output are cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld     <= '0;
         r_out_vld <= 1'b0;
         r_sum     <= '0;
         r_cout    <= 1'b0;
         r_ovf     <= 1'b0;
         r_zero    <= 1'b0;
      end else if (w_en) begin
         r_vld[0] <= w_push;
         r_a[0]   <= a;
         r_b[0]   <= b ^ {WIDTH{sub}};
         r_c[0]   <= cin ^ sub;
         r_s[0]   <= '0;
         for (int k = 1; k < L; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_a[k]   <= r_a[k-1];
            r_b[k]   <= r_b[k-1];
            r_c[k]   <= w_res[k-1][SLICE+1];
            r_s[k]   <= w_psum[k-1];
         end
         r_out_vld <= r_vld[L-1];
         r_sum     <= w_psum[L-1];
         r_cout    <= w_res[L-1][SLICE+1];
         r_ovf     <= w_res[L-1][SLICE+1] ^ w_res[L-1][SLICE];
         r_zero    <= ~|w_psum[L-1];
      end
   end

   assign out_valid = r_out_vld;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub: vector table, backpressure, mid-flight reset,
// and a 16-bit/4-bit-slice instance.
module tb_cla_pipe_addsub;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
   logic [31:0] a, b, sum;

   logic        t_in_valid, t_in_ready, t_cin, t_sub, t_out_valid, t_out_ready;
   logic        t_cout, t_ovf, t_zero;
   logic [15:0] t_a, t_b, t_sum;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   cla_pipe_addsub #(.WIDTH(32), .SLICE(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   cla_pipe_addsub #(.WIDTH(16), .SLICE(4)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
      .a(t_a), .b(t_b), .cin(t_cin), .sub(t_sub),
      .out_valid(t_out_valid), .out_ready(t_out_ready),
      .sum(t_sum), .cout(t_cout), .ovf(t_ovf), .zero(t_zero)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] e_sum;
      logic        e_cout;
      logic        e_ovf;
      logic        e_zero;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Issue one op with out_ready high, measure edges to out_valid, compare the result.
   task automatic run_vec(input string nm, input vec_t v);
      int lat;
      @(negedge clk);
      a = v.a; b = v.b; cin = v.cin; sub = v.sub;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({nm, "_latency"}, 64'(lat), 64'd4);
      check({nm, "_sum"},  {32'd0, sum},  {32'd0, v.e_sum});
      check({nm, "_cout"}, {63'd0, cout}, {63'd0, v.e_cout});
      check({nm, "_ovf"},  {63'd0, ovf},  {63'd0, v.e_ovf});
      check({nm, "_zero"}, {63'd0, zero}, {63'd0, v.e_zero});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k, pushed, popped, stall_cnt, ghosts, lat;
      bit          seen, stalled_prev;
      logic [31:0] held, expv;
      vec_t        nv;

      vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'h000000FF, 32'h00000000, 1'b1, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      vecs[9]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{32'h0000FFFF, 32'h00FF0001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};

      // Clock/reset
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      t_in_valid = 1'b0; t_out_ready = 1'b1; t_a = '0; t_b = '0; t_cin = 1'b0; t_sub = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_sum",       {32'd0, sum},       64'd0);
      check("rst_cout",      {63'd0, cout},      64'd0);
      check("rst_ovf",       {63'd0, ovf},       64'd0);
      check("rst_zero",      {63'd0, zero},      64'd0);
      check("rst_in_ready",  {63'd0, in_ready},  64'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Vector table
      for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Backpressure: 6 back-to-back adds, 3-cycle stall after first result.
      pushed = 0; popped = 0; stall_cnt = 0; seen = 1'b0; stalled_prev = 1'b0;
      held = '0; k = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 40 && popped < 6; cyc++) begin
         @(negedge clk);
         if (stalled_prev) begin
            check("bp_frozen_sum",   {32'd0, sum},       {32'd0, held});
            check("bp_frozen_valid", {63'd0, out_valid}, 64'd1);
         end
         if (out_valid) seen = 1'b1;
         if (seen && stall_cnt < 3) begin
            out_ready = 1'b0;
            stall_cnt++;
         end else begin
            out_ready = 1'b1;
         end
         if (pushed < 6) begin
            k = pushed + 1;
            a = 32'(k); b = 32'(k) << 8; cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && !out_ready) begin
            check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            held = sum;
            stalled_prev = 1'b1;
         end else begin
            stalled_prev = 1'b0;
         end
         if (popped > 0) check("bp_no_gap", {63'd0, out_valid}, 64'd1);
         if (in_valid && in_ready) begin
            exp_q.push_back(32'(k * 257));
            pushed++;
         end
         if (out_valid && out_ready) begin
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_0000;
            check($sformatf("bp_order%0d", popped), {32'd0, sum}, {32'd0, expv});
            popped++;
         end
      end
      check("bp_stall_cycles", 64'(stall_cnt), 64'd3);
      check("bp_popped",       64'(popped),    64'd6);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;

      // Reset mid-flight: three ops accepted, then a one-cycle reset.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 32'(100 + i); b = 32'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      #1;
      check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_sum",       {32'd0, sum},       64'd0);
      #1;
      check("mid_rst_in_ready_back", {63'd0, in_ready}, 64'd1);
      ghosts = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) ghosts++;
      end
      check("mid_rst_no_ghost", 64'(ghosts), 64'd0);
      nv = '{32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b0};
      run_vec("post_rst_op", nv);

      // WIDTH=16, SLICE=4 instance
      @(negedge clk);
      t_a = 16'h8000; t_b = 16'h8000; t_cin = 1'b1; t_sub = 1'b0;
      t_in_valid = 1'b1; t_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      t_in_valid = 1'b0;
      lat = 0;
      while (!t_out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("w16_latency", 64'(lat), 64'd4);
      check("w16_sum",  {48'd0, t_sum},  64'h0001);
      check("w16_cout", {63'd0, t_cout}, 64'd1);
      check("w16_ovf",  {63'd0, t_ovf},  64'd1);
      check("w16_zero", {63'd0, t_zero}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor: the next generation of the team's fixed 8-bit combinational CLA. It splits a WIDTH-bit operand pair into SLICE-bit segments, one segment per pipeline stage. Each segment is a two-level 4-bit-group CLA, and the carry between segments is registered. It takes one operation per cycle, handles backpressure with a valid/ready handshake, and produces sum, carry, signed overflow and zero flags. It sits between operand-issue logic and any consumer that needs wide add/sub at a higher clock rate than a single-cycle CLA allows.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of SLICE.
- SLICE, 8: bits resolved per pipeline stage; must be a multiple of 4. Number of stages is L = WIDTH/SLICE.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB. In subtract mode, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

## Operation
- Operand conditioning at input:
  - b_eff = b XOR {WIDTH{sub}}.
  - c0 = cin XOR sub.
  - Results: add gives a+b+cin; sub with cin=0 gives a-b; sub with cin=1 gives a-b-1.
- Stage i (0..L-1) computes slice i [i*SLICE +: SLICE] from a, b_eff and the carry registered by stage i-1 (c0 for stage 0). It then registers the slice sum and slice carry-out.
- Within a slice:
  - per-bit g = a&b, p = a^b;
  - 4-bit groups form group G/P;
  - group carries come from lookahead over G/P, not ripple.
- Input skew: the slice-i operand bits are delayed i cycles so they meet their carry.
- Output deskew: completed slices are delayed so all slices of one operation emerge together.
- Flags at the final stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero = ~|sum, registered with sum.
- Handshake:
  - Global enable en = ~out_valid | out_ready.
  - in_ready = en & ~rst.
  - A transfer occurs when in_valid & in_ready.
  - When en=0 every pipeline register, including the valid bits, holds.
- Bubbles are not compressed: a valid bit travels with each slot; empty slots advance when en=1.
- Ordering is strictly FIFO; no operation is dropped or duplicated under any stall pattern.

## Timing
- Latency: an operation accepted at edge t presents out_valid=1 with its result after edge t+L (WIDTH=32, SLICE=8 gives 4), provided en stays 1.
- Throughput: 1 operation/cycle when out_ready is held high.
- Stall: if out_valid=1 and out_ready=0, then sum/cout/ovf/zero/out_valid stay stable and in_ready=0 in the same cycle (combinational from out_ready).
- A simultaneous output pop and input push in the same cycle is legal and loses nothing.
- Reset (any cycle rst=1, sampled at the edge):
  - all valid bits clear; out_valid=0, sum=0, cout=0, ovf=0, zero=0;
  - in_ready=0 while rst=1;
  - in-flight operations are discarded and never appear.
  - After rst falls, in_ready=1 in the next cycle.
- Output data is undefined-but-stable when out_valid=0; the checker must ignore it.
- Elaboration must fail if WIDTH%SLICE != 0 or SLICE%4 != 0.

## Test plan
All scenarios use WIDTH=32, SLICE=8 unless stated.
- Full-carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> 4 cycles later sum=0x00000000, cout=1, zero=1, ovf=0.
- Subtract with borrow: a=0x00000005, b=0x00000007, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0. Same operands with cin=1 -> sum=0xFFFFFFFD.
- Signed overflow:
  - 0x7FFFFFFF+0x00000001 -> sum=0x80000000, ovf=1, cout=0.
  - sub 0x80000000-0x00000001 -> sum=0x7FFFFFFF, ovf=1, cout=1.
- Backpressure: push 6 back-to-back adds (k + k<<8, k=1..6); hold out_ready=0 for 3 cycles after the first out_valid -> outputs frozen, in_ready=0, all 6 results emerge in order with no gaps once out_ready=1.
- Reset mid-flight: accept 3 ops, assert rst for 1 cycle on the cycle after the 3rd -> out_valid=0 after that edge, none of the 3 results ever appear. A new op then returns after exactly 4 cycles.
- Alternate params WIDTH=16, SLICE=4: 0x8000+0x8000, cin=1 -> after 4 cycles sum=0x0001, cout=1, ovf=1, zero=0.
